// File: rtl/tilelink_initiator_pkg.sv
// TileLink-UL shared types: A/D channel structs, opcodes and the initiator state enum.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Ports: none. Imported by the initiator, by monitors and by benches that
// need to decode bus fields or the initiator state.
package tilelink_initiator_pkg;

  // A-channel opcodes used by TL-UL initiators.
  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } tl_a_op_e;

  // D-channel opcodes returned by TL-UL responders.
  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } tl_d_op_e;

  // Initiator-driven bundle. a_ready is the initiator's readiness to take a
  // D beat; this initiator always has room for its single response.
  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_ready;
  } tilelink_a;

  // Responder-driven bundle. d_ready is the responder's readiness to take an
  // A beat.
  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        d_ready;
  } tilelink_d;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } tl_init_state_e;

  // Full-word writes use PutFullData; any partial lane mask needs PutPartialData.
  function automatic tl_a_op_e put_opcode(input logic [3:0] mask);
    tl_a_op_e op;
    if (mask == 4'hF) op = PutFullData;
    else              op = PutPartialData;
    return op;
  endfunction

endpackage

// File: rtl/tilelink_initiator.sv
// Single-outstanding TL-UL initiator: command/response handshake in, one A request out, waits for D.
// Latency: cmd accept edge 0 -> a_valid cycle 1 -> (zero-wait responder) rsp_valid cycle 3; timeout forces rsp after TIMEOUT cycles.
// Backpressure: cmd_ready only in IDLE; A held until d_ready; RESP holds until rsp_ready; late D beats are dropped.
//
// Ports:
//   clock, reset_n                 clock and async active-low reset
//   cmd_valid/cmd_ready            command handshake (write, addr, data, mask)
//   rsp_valid/rsp_ready            response handshake (data, error, timeout flag)
//   bus_tla                        registered TL-UL A-channel bundle
//   tick_tld                       TL-UL D-channel bundle from the responder
module tilelink_initiator
  import tilelink_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [7:0]  SOURCE_ID = 8'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [3:0]  cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output tilelink_a   bus_tla,
  input  tilelink_d   tick_tld
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam tilelink_a A_RESET = '{
    a_valid:   1'b0,
    a_opcode:  Get,
    a_param:   3'd0,
    a_size:    2'd2,
    a_source:  SOURCE_ID,
    a_address: 32'd0,
    a_mask:    4'd0,
    a_data:    32'd0,
    a_ready:   1'b1
  };

  tl_init_state_e state_q, state_d;
  tilelink_a      a_q, a_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_data_q, rsp_data_d;
  logic           rsp_error_q, rsp_error_d;
  logic           rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Held low through reset and the first edge after release, so a command
  // cannot be taken while the block is still coming out of reset.
  logic           live_q;
  logic           cnt_hit;
  logic           to_fire;

  assign cnt_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;
    to_fire       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          a_d.a_address = cmd_addr;
          a_d.a_size    = 2'd2;
          a_d.a_valid   = 1'b1;
          if (cmd_write) begin
            a_d.a_opcode = put_opcode(cmd_mask);
            a_d.a_mask   = cmd_mask;
            a_d.a_data   = cmd_data;
          end else begin
            a_d.a_opcode = Get;
            a_d.a_mask   = 4'hF;
            a_d.a_data   = 32'd0;
          end
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A request stalled past the budget is abandoned like a missing response.
        if (cnt_hit) begin
          to_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (tick_tld.d_ready) begin
            a_d.a_valid = 1'b0;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        // A real response on the deadline cycle beats the timeout.
        if (tick_tld.d_valid) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = tick_tld.d_data;
          rsp_error_d   = tick_tld.d_error;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (cnt_hit) begin
          to_fire = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (to_fire) begin
      a_d.a_valid   = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_data_d    = 32'd0;
      rsp_error_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      state_d       = RESP;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      a_q           <= A_RESET;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 32'd0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
      live_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
      live_q        <= 1'b1;
    end
  end

  assign cmd_ready   = live_q && (state_q == IDLE);
  assign bus_tla     = a_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign rsp_timeout = rsp_timeout_q;

  // D opcode, param, size and source carry nothing this single-outstanding
  // initiator needs.
  logic unused_d;
  assign unused_d = ^{tick_tld.d_opcode, tick_tld.d_param, tick_tld.d_size,
                      tick_tld.d_source};

endmodule

// File: tb/tb_tilelink_initiator.sv
// Bench for tilelink_initiator: table of single transactions against a small
// register-style responder, plus hand sequences for backpressure, stall and reset.
module tb_tilelink_initiator;
  import tilelink_initiator_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_data;
  logic [3:0]  cmd_mask;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_data;
  tilelink_a   bus_tla;
  tilelink_d   tick_tld;

  tilelink_initiator #(.TIMEOUT(16), .SOURCE_ID(8'd0)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .bus_tla(bus_tla), .tick_tld(tick_tld)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- responder model ----------------
  // Maps addr[31:28]==0, 16 words; 0x0FFC answers with an error. Answers one
  // cycle after the A beat is accepted.
  logic        d_ready;
  logic        rd_valid, rd_err;
  logic [31:0] rd_data;
  tl_d_op_e    rd_op;
  logic        inj_valid, inj_err;
  logic [31:0] inj_data;
  logic [31:0] mem [16];
  logic [3:0]  a_idx;

  assign a_idx = bus_tla.a_address[5:2];

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= 32'd0;
      rd_op    <= AccessAck;
      for (int k = 0; k < 16; k++) mem[k] <= 32'd0;
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= 32'd0;
      rd_op    <= AccessAck;
      if (bus_tla.a_valid && d_ready && bus_tla.a_address[31:28] == 4'h0) begin
        rd_valid <= 1'b1;
        if (bus_tla.a_address == 32'h0000_0FFC) begin
          rd_err  <= 1'b1;
          rd_data <= 32'hE0E0_E0E0;
        end else if (bus_tla.a_opcode == Get) begin
          rd_op   <= AccessAckData;
          rd_data <= mem[a_idx];
        end else begin
          mem[a_idx] <= merge(mem[a_idx], bus_tla.a_data, bus_tla.a_mask);
        end
      end
    end
  end

  always_comb begin
    tick_tld          = '0;
    tick_tld.d_valid  = rd_valid | inj_valid;
    tick_tld.d_opcode = rd_op;
    tick_tld.d_data   = inj_valid ? inj_data : rd_data;
    tick_tld.d_error  = inj_valid ? inj_err : rd_err;
    tick_tld.d_ready  = d_ready;
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [2:0]  e_op;
    logic [3:0]  e_mask;
    logic [31:0] e_adata;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_to;
    int          e_lat;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    //        wr    addr          data          mask  op    amask adata         rdata         err   to    lat
    vt[0]  = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 3'd0, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0, 3};
    vt[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 3'd4, 4'hF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 3};
    vt[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'h3, 3'd1, 4'h3, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 3};
    vt[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 3'd4, 4'hF, 32'h0000_0000, 32'hDEAD_5678, 1'b0, 1'b0, 3};
    vt[4]  = '{1'b0, 32'h1000_0000, 32'h0000_0000, 4'h0, 3'd4, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 17};
    vt[5]  = '{1'b0, 32'h0000_0FFC, 32'h5555_5555, 4'h2, 3'd4, 4'hF, 32'h0000_0000, 32'hE0E0_E0E0, 1'b1, 1'b0, 3};
    vt[6]  = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF, 3'd0, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0, 3};
    vt[7]  = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'h8, 3'd1, 4'h8, 32'h1122_3344, 32'h0000_0000, 1'b0, 1'b0, 3};
    vt[8]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 4'h0, 3'd4, 4'hF, 32'h0000_0000, 32'h11FE_F00D, 1'b0, 1'b0, 3};
    vt[9]  = '{1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 4'h0, 3'd1, 4'h0, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0, 1'b0, 3};
    vt[10] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 4'h0, 3'd4, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 3};

    reset_n   = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    rsp_ready = 1'b1;
    d_ready   = 1'b1;
    inj_valid = 1'b0; inj_err = 1'b0; inj_data = '0;
    #1 reset_n = 1'b0;

    // ---- reset state ----
    @(negedge clock);
    chk("rst a_valid",   bus_tla.a_valid,   1'b0);
    chk("rst a_opcode",  bus_tla.a_opcode,  3'd4);
    chk("rst a_param",   bus_tla.a_param,   3'd0);
    chk("rst a_size",    bus_tla.a_size,    2'd2);
    chk("rst a_source",  bus_tla.a_source,  8'd0);
    chk("rst a_address", bus_tla.a_address, 32'd0);
    chk("rst a_mask",    bus_tla.a_mask,    4'd0);
    chk("rst a_data",    bus_tla.a_data,    32'd0);
    chk("rst a_ready",   bus_tla.a_ready,   1'b1);
    chk("rst rsp_valid", rsp_valid,   1'b0);
    chk("rst rsp_data",  rsp_data,    32'd0);
    chk("rst rsp_error", rsp_error,   1'b0);
    chk("rst rsp_to",    rsp_timeout, 1'b0);
    chk("rst cmd_ready", cmd_ready,   1'b0);
    reset_n = 1'b1;

    // ---- table: one transaction per vector, rsp_ready tied high ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clock);
      chk($sformatf("v%0d cmd_ready idle", i), cmd_ready, 1'b1);
      cmd_valid = 1'b1; cmd_write = vt[i].wr; cmd_addr = vt[i].addr;
      cmd_data = vt[i].data; cmd_mask = vt[i].mask;
      @(negedge clock);   // cycle 1
      cmd_valid = 1'b0; cmd_data = 32'hFFFF_FFFF; cmd_addr = 32'hFFFF_FFFF;
      chk($sformatf("v%0d a_valid", i),   bus_tla.a_valid,   1'b1);
      chk($sformatf("v%0d a_opcode", i),  bus_tla.a_opcode,  vt[i].e_op);
      chk($sformatf("v%0d a_mask", i),    bus_tla.a_mask,    vt[i].e_mask);
      chk($sformatf("v%0d a_data", i),    bus_tla.a_data,    vt[i].e_adata);
      chk($sformatf("v%0d a_address", i), bus_tla.a_address, vt[i].addr);
      chk($sformatf("v%0d a_size", i),    bus_tla.a_size,    2'd2);
      chk($sformatf("v%0d cmd_ready busy", i), cmd_ready, 1'b0);
      @(negedge clock);   // cycle 2
      chk($sformatf("v%0d a_valid one beat", i), bus_tla.a_valid, 1'b0);
      cyc = 2;
      while (!rsp_valid && cyc < 40) begin
        @(negedge clock);
        cyc++;
      end
      chk($sformatf("v%0d rsp latency", i), cyc, vt[i].e_lat);
      chk($sformatf("v%0d rsp_data", i),    rsp_data,    vt[i].e_rdata);
      chk($sformatf("v%0d rsp_error", i),   rsp_error,   vt[i].e_err);
      chk($sformatf("v%0d rsp_timeout", i), rsp_timeout, vt[i].e_to);
      chk($sformatf("v%0d cmd_ready resp", i), cmd_ready, 1'b0);
      @(negedge clock);
      chk($sformatf("v%0d rsp_valid drop", i), rsp_valid, 1'b0);
      chk($sformatf("v%0d cmd_ready back", i), cmd_ready, 1'b1);
      // Stray D beat while idle must not produce a response.
      inj_valid = 1'b1; inj_data = 32'hBAD0_BAD0; inj_err = 1'b1;
      @(negedge clock);
      inj_valid = 1'b0;
      chk($sformatf("v%0d late d ignored", i), rsp_valid, 1'b0);
      chk($sformatf("v%0d late d a_valid", i), bus_tla.a_valid, 1'b0);
    end

    // ---- response backpressure ----
    rsp_ready = 1'b0;
    @(negedge clock);
    chk("bp cmd_ready", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_mask = 4'h0;
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);   // cycle 3
    chk("bp rsp_valid", rsp_valid, 1'b1);
    chk("bp rsp_data",  rsp_data,  32'hDEAD_5678);
    // Offer a write while the response is pending; it must wait for IDLE.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 32'hFFFF_FFFF; cmd_mask = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("bp%0d rsp_valid", k), rsp_valid, 1'b1);
      chk($sformatf("bp%0d rsp_data", k),  rsp_data,  32'hDEAD_5678);
      chk($sformatf("bp%0d rsp_error", k), rsp_error, 1'b0);
      chk($sformatf("bp%0d cmd_ready", k), cmd_ready, 1'b0);
      chk($sformatf("bp%0d a_valid", k),   bus_tla.a_valid, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    chk("bp release rsp_valid", rsp_valid, 1'b0);
    chk("bp release cmd_ready", cmd_ready, 1'b1);
    chk("bp no same-cycle cmd", bus_tla.a_valid, 1'b0);
    cmd_valid = 1'b0;

    // ---- A-channel stall, then reset while waiting (unmapped, never answered) ----
    @(negedge clock);
    d_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h2000_0020;
    cmd_data = 32'h0BAD_F00D; cmd_mask = 4'hF;
    @(negedge clock);
    cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_data = 32'h0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d a_valid", k),   bus_tla.a_valid,   1'b1);
      chk($sformatf("stall%0d a_address", k), bus_tla.a_address, 32'h2000_0020);
      chk($sformatf("stall%0d a_data", k),    bus_tla.a_data,    32'h0BAD_F00D);
      chk($sformatf("stall%0d a_opcode", k),  bus_tla.a_opcode,  3'd0);
      if (k == 2) d_ready = 1'b1;
      @(negedge clock);
    end
    chk("stall accepted", bus_tla.a_valid, 1'b0);
    chk("wait cmd_ready", cmd_ready, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("wait rst a_valid",   bus_tla.a_valid, 1'b0);
    chk("wait rst rsp_valid", rsp_valid,       1'b0);
    chk("wait rst cmd_ready", cmd_ready,       1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("wait rel cmd_ready", cmd_ready, 1'b1);
    chk("wait rel rsp_valid", rsp_valid, 1'b0);

    // ---- reset while the A beat is still stalled ----
    d_ready = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0010; cmd_mask = 4'h0;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("req a_valid", bus_tla.a_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("req rst a_valid",   bus_tla.a_valid,   1'b0);
    chk("req rst a_address", bus_tla.a_address, 32'd0);
    chk("req rst cmd_ready", cmd_ready,         1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    d_ready = 1'b1;
    @(negedge clock);
    chk("req rel cmd_ready", cmd_ready, 1'b1);
    chk("req rel a_valid",   bus_tla.a_valid, 1'b0);
    chk("req rel rsp_valid", rsp_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
